// File: rtl/ucie_ctl_sb_pkg.sv
// Sideband message decode: code constants, field constants, decode entry and lookup.
// Pure definitions; no timing or flow control of its own.
package ucie_ctl_sb_pkg;

  localparam int SB_CODE_W   = 5;
  localparam int SB_FIELDS_W = 8;  // op + msg + sub + info + sel

  localparam logic [SB_CODE_W-1:0] SB_CODE_OP   = 5'b00000;
  localparam logic [SB_CODE_W-1:0] SB_CODE_M1S1 = 5'b10101;
  localparam logic [SB_CODE_W-1:0] SB_CODE_M1S3 = 5'b10111;
  localparam logic [SB_CODE_W-1:0] SB_CODE_M2S1 = 5'b11001;
  localparam logic [SB_CODE_W-1:0] SB_CODE_M2S3 = 5'b11011;
  localparam logic [SB_CODE_W-1:0] SB_CODE_M3S0 = 5'b11100;
  localparam logic [SB_CODE_W-1:0] SB_CODE_M3S1 = 5'b11101;
  localparam logic [SB_CODE_W-1:0] SB_CODE_M3S2 = 5'b11110;

  localparam logic [1:0] SB_MSG_ADDR_0 = 2'd0;
  localparam logic [1:0] SB_MSG_ADDR_1 = 2'd1;
  localparam logic [1:0] SB_MSG_ADDR_2 = 2'd2;
  localparam logic [1:0] SB_MSG_ADDR_3 = 2'd3;
  localparam logic [1:0] SB_SEL_NONE   = 2'b00;
  localparam logic [1:0] SB_SEL_OP     = 2'b01;

  typedef struct packed {
    logic       supp;
    logic       op;
    logic [1:0] msg;
    logic [1:0] sub;
    logic       info;
    logic [1:0] sel;
  } sb_dec_t;

  function automatic sb_dec_t sb_lookup(input logic [SB_CODE_W-1:0] code);
    sb_dec_t d;
    d = '0;
    d.supp = 1'b1;
    case (code)
      SB_CODE_OP:   {d.op, d.msg, d.sub, d.sel} = {1'b1, SB_MSG_ADDR_0, 2'd0, SB_SEL_OP};
      SB_CODE_M1S1: {d.op, d.msg, d.sub, d.sel} = {1'b0, SB_MSG_ADDR_1, 2'd1, SB_SEL_NONE};
      SB_CODE_M1S3: {d.op, d.msg, d.sub, d.sel} = {1'b0, SB_MSG_ADDR_1, 2'd3, SB_SEL_NONE};
      SB_CODE_M2S1: {d.op, d.msg, d.sub, d.sel} = {1'b0, SB_MSG_ADDR_2, 2'd1, SB_SEL_NONE};
      SB_CODE_M2S3: {d.op, d.msg, d.sub, d.sel} = {1'b0, SB_MSG_ADDR_2, 2'd3, SB_SEL_NONE};
      SB_CODE_M3S0: {d.op, d.msg, d.sub, d.sel} = {1'b0, SB_MSG_ADDR_3, 2'd0, SB_SEL_NONE};
      SB_CODE_M3S1: {d.op, d.msg, d.sub, d.sel} = {1'b0, SB_MSG_ADDR_3, 2'd1, SB_SEL_NONE};
      SB_CODE_M3S2: {d.op, d.msg, d.sub, d.sel} = {1'b0, SB_MSG_ADDR_3, 2'd2, SB_SEL_NONE};
      default:      d.supp = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_msg_dispatcher_if.sv
// Request channels in, queued decoded message out, plus error pulse and occupancy.
// Valid/ready on both sides; slave is the dispatcher, master is its environment.
interface ucie_ctl_sb_msg_dispatcher_if #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DEC_W      = 5
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0]       i_req_valid;
  logic [NUM_CH*DEC_W-1:0] i_req_decode;
  logic [NUM_CH-1:0]       o_req_ready;
  logic                    i_flush;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_op_addr;
  logic [1:0]              o_msg_addr;
  logic [1:0]              o_sub_addr;
  logic                    o_info_addr;
  logic [1:0]              o_sel_data;
  logic                    o_ignore_data2;
  logic [CH_W-1:0]         o_ch_id;
  logic                    o_err_unsup;
  logic [CH_W-1:0]         o_err_ch;
  logic [CNT_W-1:0]        o_count;

  modport slave (
    input  i_req_valid, i_req_decode, i_flush, i_ready,
    output o_req_ready, o_valid, o_op_addr, o_msg_addr, o_sub_addr, o_info_addr,
           o_sel_data, o_ignore_data2, o_ch_id, o_err_unsup, o_err_ch, o_count
  );

  modport master (
    output i_req_valid, i_req_decode, i_flush, i_ready,
    input  o_req_ready, o_valid, o_op_addr, o_msg_addr, o_sub_addr, o_info_addr,
           o_sel_data, o_ignore_data2, o_ch_id, o_err_unsup, o_err_ch, o_count
  );
endinterface

// File: rtl/ucie_ctl_sb_sync_fifo.sv
// Register-based synchronous FIFO; write visible at head one cycle later, no bypass.
// Push ignored when full (even with a same-cycle pop), pop ignored when empty; flush wins.
module ucie_ctl_sb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign o_full  = (cnt == CW'(DEPTH));
  assign o_empty = (cnt == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem[wr_ptr] <= i_wdata;
  end

  assign o_rdata = mem[rd_ptr];
  assign o_count = cnt;

endmodule

// File: rtl/ucie_ctl_sb_msg_dispatcher.sv
// Round-robin picks one request channel per cycle, decodes it and queues supported messages.
// Head appears one cycle after accept; a full queue stalls supported codes but still drains unsupported ones.
module ucie_ctl_sb_msg_dispatcher
  import ucie_ctl_sb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DEC_W      = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  ucie_ctl_sb_msg_dispatcher_if.slave   bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = SB_FIELDS_W + CH_W;

  logic [CH_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [DEC_W-1:0]  gnt_code;
  sb_dec_t           dec;
  logic              accept, push, full, empty;
  logic [ENT_W-1:0]  wdata, rdata;
  logic [CNT_W-1:0]  count;
  logic              err_unsup;
  logic [CH_W-1:0]   err_ch;
  int                idx;

  // First valid channel scanning upward from rr_ptr, wrapping.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!gnt_any && bus.i_req_valid[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = CH_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign gnt_code = bus.i_req_decode[gnt_idx*DEC_W +: DEC_W];
  assign dec      = sb_lookup(SB_CODE_W'(gnt_code));
  assign accept   = gnt_any & (~full | ~dec.supp) & ~bus.i_flush & i_rst;
  assign push     = accept & dec.supp;
  assign wdata    = {dec.op, dec.msg, dec.sub, dec.info, dec.sel, gnt_idx};

  assign bus.o_req_ready = accept ? grant : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr    <= '0;
      err_unsup <= 1'b0;
      err_ch    <= '0;
    end else begin
      if (accept)
        rr_ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      err_unsup <= accept & ~dec.supp;
      err_ch    <= (accept & ~dec.supp) ? gnt_idx : '0;
    end
  end

  ucie_ctl_sb_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (wdata),
    .i_pop   (bus.i_ready),
    .i_flush (bus.i_flush),
    .o_rdata (rdata),
    .o_full  (full),
    .o_empty (empty),
    .o_count (count)
  );

  // Head fields are masked while empty so stale storage never leaks out.
  assign bus.o_valid        = ~empty;
  assign bus.o_ignore_data2 = ~empty;
  assign {bus.o_op_addr, bus.o_msg_addr, bus.o_sub_addr, bus.o_info_addr,
          bus.o_sel_data, bus.o_ch_id} = empty ? '0 : rdata;
  assign bus.o_count        = count;
  assign bus.o_err_unsup    = err_unsup;
  assign bus.o_err_ch       = err_ch;

endmodule

// File: tb/tb_ucie_ctl_sb_msg_dispatcher.sv
// Directed vector table plus hand sequences for full, flush and reset corners.
module tb_ucie_ctl_sb_msg_dispatcher;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 i_clk = ~i_clk;

  ucie_ctl_sb_msg_dispatcher_if #(.NUM_CH(2), .FIFO_DEPTH(4), .DEC_W(5)) bus ();

  ucie_ctl_sb_msg_dispatcher #(.NUM_CH(2), .FIFO_DEPTH(4), .DEC_W(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] vld;
    logic [4:0] d0;
    logic [4:0] d1;
    logic       rdy;
    logic [1:0] exp_rr;
    logic       exp_v;
    int         exp_cnt;
    logic [7:0] exp_head;  // {op, msg, sub, sel, ch}
    logic       exp_err;
    logic       exp_ech;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] head();
    return {bus.o_op_addr, bus.o_msg_addr, bus.o_sub_addr, bus.o_sel_data, bus.o_ch_id};
  endfunction

  task automatic drive(input logic [1:0] vld, input logic [4:0] d0, input logic [4:0] d1,
                       input logic rdy, input logic flush);
    bus.i_req_valid  = vld;
    bus.i_req_decode = {d1, d0};
    bus.i_ready      = rdy;
    bus.i_flush      = flush;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, int'(bus.o_valid), 0);
    chk({tag, " count"}, int'(bus.o_count), 0);
    chk({tag, " ready"}, int'(bus.o_req_ready), 0);
    chk({tag, " ign"},   int'(bus.o_ignore_data2), 0);
    chk({tag, " head"},  int'(head()), 0);
    chk({tag, " info"},  int'(bus.o_info_addr), 0);
    chk({tag, " err"},   int'(bus.o_err_unsup), 0);
    chk({tag, " errch"}, int'(bus.o_err_ch), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b01, 5'b10111, 5'b00000, 1'b0, 2'b01, 1'b1, 1, 8'b00111000, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 5'b00000, 5'b11100, 1'b0, 2'b10, 1'b1, 2, 8'b00111000, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 5'b00000, 5'b11100, 1'b0, 2'b01, 1'b1, 3, 8'b00111000, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 5'b00000, 5'b11100, 1'b1, 2'b10, 1'b1, 3, 8'b01100001, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 5'b00000, 5'b00000, 1'b1, 2'b00, 1'b1, 2, 8'b10000010, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 5'b00000, 5'b01010, 1'b0, 2'b10, 1'b1, 2, 8'b10000010, 1'b1, 1'b1};
    vecs[6] = '{2'b00, 5'b00000, 5'b00000, 1'b0, 2'b00, 1'b1, 2, 8'b10000010, 1'b0, 1'b0};
    vecs[7] = '{2'b00, 5'b00000, 5'b00000, 1'b1, 2'b00, 1'b1, 1, 8'b01100001, 1'b0, 1'b0};
    vecs[8] = '{2'b00, 5'b00000, 5'b00000, 1'b1, 2'b00, 1'b0, 0, 8'b00000000, 1'b0, 1'b0};
    vecs[9] = '{2'b00, 5'b00000, 5'b00000, 1'b1, 2'b00, 1'b0, 0, 8'b00000000, 1'b0, 1'b0};

    // Reset state, with a request pending to show ready stays low in reset.
    drive(2'b01, 5'b10111, 5'b00000, 1'b1, 1'b0);
    tick();
    chk_zero("reset");
    drive(2'b00, 5'b00000, 5'b00000, 1'b0, 1'b0);
    tick();
    #2 i_rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].rdy, 1'b0);
      #1;
      chk($sformatf("v%0d ready", i), int'(bus.o_req_ready), int'(vecs[i].exp_rr));
      tick();
      chk($sformatf("v%0d valid", i), int'(bus.o_valid), int'(vecs[i].exp_v));
      chk($sformatf("v%0d ign", i),   int'(bus.o_ignore_data2), int'(vecs[i].exp_v));
      chk($sformatf("v%0d count", i), int'(bus.o_count), vecs[i].exp_cnt);
      chk($sformatf("v%0d head", i),  int'(head()), int'(vecs[i].exp_head));
      chk($sformatf("v%0d err", i),   int'(bus.o_err_unsup), int'(vecs[i].exp_err));
      if (vecs[i].exp_err)
        chk($sformatf("v%0d errch", i), int'(bus.o_err_ch), int'(vecs[i].exp_ech));
    end

    // Fill to capacity from ch0; the fifth request must stall.
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 5'b11001, 5'b00000, 1'b0, 1'b0);
      #1;
      chk($sformatf("fill%0d ready", i), int'(bus.o_req_ready), 1);
      tick();
    end
    chk("full count", int'(bus.o_count), 4);
    #1;
    chk("full stall ready", int'(bus.o_req_ready), 0);
    tick();
    chk("full stall count", int'(bus.o_count), 4);

    // Unsupported codes drain even when full.
    drive(2'b10, 5'b00000, 5'b01010, 1'b0, 1'b0);
    #1;
    chk("full unsup ready", int'(bus.o_req_ready), 2);
    tick();
    chk("full unsup err", int'(bus.o_err_unsup), 1);
    chk("full unsup count", int'(bus.o_count), 4);

    // Pop while full does not open a push slot in the same cycle.
    drive(2'b01, 5'b11001, 5'b00000, 1'b1, 1'b0);
    #1;
    chk("pop full ready", int'(bus.o_req_ready), 0);
    tick();
    chk("pop full count", int'(bus.o_count), 3);
    chk("err single pulse", int'(bus.o_err_unsup), 0);
    drive(2'b01, 5'b11001, 5'b00000, 1'b0, 1'b0);
    #1;
    chk("after pop ready", int'(bus.o_req_ready), 1);
    tick();
    chk("after pop count", int'(bus.o_count), 4);

    // Flush with 3 entries and a concurrent request.
    drive(2'b00, 5'b00000, 5'b00000, 1'b1, 1'b0);
    tick();
    chk("preflush count", int'(bus.o_count), 3);
    drive(2'b01, 5'b11001, 5'b00000, 1'b1, 1'b1);
    #1;
    chk("flush ready", int'(bus.o_req_ready), 0);
    tick();
    drive(2'b00, 5'b00000, 5'b00000, 1'b0, 1'b0);
    chk("flush count", int'(bus.o_count), 0);
    chk("flush valid", int'(bus.o_valid), 0);

    // Last accepted channel was ch0, so rr_ptr survives flush pointing at ch1.
    drive(2'b11, 5'b11001, 5'b11001, 1'b0, 1'b0);
    #1;
    chk("rr kept ready", int'(bus.o_req_ready), 2);
    tick();
    chk("rr kept count", int'(bus.o_count), 1);
    chk("rr kept head", int'(head()), 8'b01001001);

    // Refill, leave an error pulse in flight, then reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 5'b11101, 5'b00000, 1'b0, 1'b0);
      tick();
    end
    chk("refill count", int'(bus.o_count), 4);
    drive(2'b10, 5'b00000, 5'b01010, 1'b1, 1'b0);
    tick();
    chk("pre-reset err", int'(bus.o_err_unsup), 1);
    chk("pre-reset count", int'(bus.o_count), 3);
    drive(2'b01, 5'b11101, 5'b00000, 1'b1, 1'b0);
    i_rst = 1'b0;
    #1;
    chk_zero("async reset");
    tick();
    tick();
    drive(2'b00, 5'b00000, 5'b00000, 1'b0, 1'b0);
    #2 i_rst = 1'b1;
    tick();
    chk("post-reset count", int'(bus.o_count), 0);
    chk("post-reset valid", int'(bus.o_valid), 0);
    chk("post-reset err", int'(bus.o_err_unsup), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_sb_msg_dispatcher.md
UCIE_CTL_SB_MSG_DISPATCHER -- requirements
Module: ucie_ctl_sb_msg_dispatcher

Interface
REQ-001 Parameter NUM_CH, default 2: number of decoded-message request channels (legal range 1..8).
REQ-002 Parameter FIFO_DEPTH, default 4: number of queued message entries (power of 2, at least 2).
REQ-003 Parameter DEC_W, default 5: width of the decode code.
REQ-004 Port i_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port i_rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port i_req_valid, input, NUM_CH: per-channel request valid.
REQ-007 Port i_req_decode, input, NUM_CH*DEC_W: per-channel decode code; channel k occupies bits [k*DEC_W +: DEC_W].
REQ-008 Port o_req_ready, output, NUM_CH: per-channel accept; a transfer occurs when valid and ready are both high.
REQ-009 Port i_flush, input, 1: synchronous queue clear.
REQ-010 Port o_valid, output, 1: the queue head is presented on the output fields.
REQ-011 Port i_ready, input, 1: the consumer takes the head.
REQ-012 Output fields of the head entry: o_op_addr (1 bit), o_msg_addr (2), o_sub_addr (2), o_info_addr (1), o_sel_data (2), o_ignore_data2 (1), o_ch_id (clog2(NUM_CH), minimum 1 bit).
REQ-013 Port o_err_unsup, output, 1, and port o_err_ch, output, clog2(NUM_CH): one-cycle pulse and channel for an unsupported code.
REQ-014 Port o_count, output, clog2(FIFO_DEPTH)+1: queue occupancy.

Function
REQ-015 Decode table, as {op, msg, sub, sel}:
- 00000 -> {1, 0, 0, 01}
- 10101 -> {0, 1, 1, 00}
- 10111 -> {0, 1, 3, 00}
- 11001 -> {0, 2, 1, 00}
- 11011 -> {0, 2, 3, 00}
- 11100 -> {0, 3, 0, 00}
- 11101 -> {0, 3, 1, 00}
- 11110 -> {0, 3, 2, 00}
- info is always 0.
REQ-016 Arbitration is round-robin and grants at most one channel per cycle: the lowest-indexed valid channel at or after rr_ptr.
REQ-017 After each grant, rr_ptr becomes (granted index + 1) mod NUM_CH; with no grant, rr_ptr holds.
REQ-018 o_req_ready[k] = grant[k] & (!full | unsupported code) & !i_flush; this path is combinational.
REQ-019 A granted supported code is written into the queue tail together with its channel id.
REQ-020 A granted unsupported code is consumed but not queued; o_err_unsup pulses on the next cycle with o_err_ch = channel.
REQ-021 o_valid = !empty; output fields are driven from registered head storage; o_ignore_data2 = o_valid.
REQ-022 Latency: an accepted request appears at the head no earlier than the next cycle; there is no combinational bypass.
REQ-023 Pop occurs when o_valid & i_ready.
REQ-024 Simultaneous push and pop: o_count is unchanged and the head advances.
REQ-025 Full: no supported request is accepted, and a pop in the same cycle does not enable a push.
REQ-026 Empty: o_valid = 0 and i_ready is ignored.
REQ-027 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-028 i_flush: next cycle o_count = 0 and o_valid = 0; it overrides push and pop; rr_ptr is preserved.
REQ-029 The head entry is stable while o_valid & !i_ready.

Reset
REQ-030 While i_rst is low, all outputs are 0, pointers and o_count are 0, rr_ptr is 0, and o_err_unsup is 0.
REQ-031 Asserting i_rst mid-transfer discards all queued entries; no pulse or entry survives reset.

Structure
REQ-032 The decode code constants, the address constants, the decode-entry struct typedef and the lookup function belong in the shared package ucie_ctl_sb_pkg.
REQ-033 The queue is the sub-module ucie_ctl_sb_sync_fifo, parametrised by WIDTH and DEPTH, with full, empty and count outputs.
REQ-034 The arbiter and decode logic stay in the top level.

Verification
REQ-035 Reset then single request: ch0 sends 10111 -> next cycle o_valid = 1, msg = 1, sub = 3, op = 0, sel = 00, ch_id = 0.
REQ-036 Contention: ch0 and ch1 both hold valid for 4 cycles with rr_ptr = 0 -> grants 0, 1, 0, 1 and queue order matches.
REQ-037 Backpressure: i_ready = 0 and 5 supported requests at FIFO_DEPTH = 4 -> 4 accepted, o_count = 4, the fifth stalls; one pop then accepts it.
REQ-038 Unsupported: ch1 sends 01010 -> o_req_ready[1] = 1, o_err_unsup pulses once with o_err_ch = 1, o_count unchanged.
REQ-039 Flush with 3 entries plus a concurrent push -> next cycle o_count = 0, o_valid = 0, the push is not accepted.
REQ-040 Full with simultaneous pop, then asynchronous reset mid-stream -> count drops to 3 without a push, then all outputs are 0 immediately on reset.
